// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: shared constants and types for the async FIFO read-side output stage
package async_fifo_pkg;
    localparam int RD_BUF_DEPTH = 2;
    typedef logic [1:0] rd_occ_t;
endpackage

// File: rtl/rd_fwft_stage_if.sv
// rd_fwft_stage_if: pop-side and stream-side signals of the read output stage
interface rd_fwft_stage_if #(parameter int DATA_WIDTH = 8);
    import async_fifo_pkg::*;
    logic                  rempty;
    logic                  rinc;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  rready;
    rd_occ_t               occupancy;
    modport master (input rempty, input mem_rdata, input rready, output rinc, output rdata, output rvalid, output occupancy);
    modport slave (output rempty, output mem_rdata, output rready, input rinc, input rdata, input rvalid, input occupancy);
endinterface

// File: rtl/rd_fwft_stage.sv
// rd_fwft_stage: turns rinc/rempty pops with 1-cycle memory latency into a FWFT valid/ready stream
module rd_fwft_stage
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input logic             rclk,
    input logic             rrst_n,
    rd_fwft_stage_if.master bus
);
    typedef logic [DATA_WIDTH-1:0] word_t;
    word_t   r_buf [RD_BUF_DEPTH];
    logic    r_head;
    rd_occ_t r_occ;
    logic    r_pend;
    logic       w_fire;
    logic [2:0] w_free;
    logic       w_wr_idx;
    assign w_fire   = bus.rvalid & bus.rready;
    assign w_free   = 3'd2 - {1'b0, r_occ} - {2'b0, r_pend} + {2'b0, w_fire};
    // The slot after the last held word is head+occ; when the head leaves in the same
    // cycle the surviving word moves to the head and the new word still lands behind it.
    assign w_wr_idx = r_head ^ r_occ[0];
    assign bus.rinc      = ~bus.rempty & (w_free != 3'd0);
    assign bus.rvalid    = r_occ != 2'd0;
    assign bus.rdata     = r_buf[r_head];
    assign bus.occupancy = r_occ;
    // Capture the word popped last cycle, retire the head on a handshake, track fill level.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int i = 0; i < RD_BUF_DEPTH; i++) r_buf[i] <= '0;
            r_head <= 1'b0;
            r_occ  <= '0;
            r_pend <= 1'b0;
        end else begin
            if (r_pend) r_buf[w_wr_idx] <= bus.mem_rdata;
            r_head <= r_head ^ w_fire;
            r_occ  <= r_occ + {1'b0, r_pend} - {1'b0, w_fire};
            r_pend <= bus.rinc;
        end
    end
    // Buffered plus in-flight words can never exceed the two buffer slots.
    assert property (@(posedge rclk) disable iff (!rrst_n) (3'(r_occ) + 3'(r_pend)) <= 3'd2);
endmodule

// File: tb/tb_rd_fwft_stage.sv
// tb_rd_fwft_stage: scenario and randomized scoreboard checks of the FWFT read stage
module tb_rd_fwft_stage;
    logic clk = 1'b0;
    logic rrst_n;
    int n_cmp = 0;
    int n_bad = 0;
    int n_pops = 0;
    logic [7:0] expq[$];
    logic [7:0] src[$];
    logic pend_m;
    rd_fwft_stage_if #(.DATA_WIDTH(8)) bus();
    rd_fwft_stage #(.DATA_WIDTH(8)) dut (.rclk(clk), .rrst_n(rrst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic drive(input logic e, input logic r);
        bus.rempty = e;
        bus.rready = r;
        #1;
    endtask
    // Advance one clock; the memory model presents each popped word in the following cycle.
    task automatic step();
        logic pop, fire;
        logic [7:0] w;
        pop  = bus.rinc & ~bus.rempty;
        fire = bus.rvalid & bus.rready;
        @(posedge clk);
        #1;
        if (fire && expq.size() != 0) void'(expq.pop_front());
        if (pop) begin
            w = (src.size() != 0) ? src.pop_front() : 8'($urandom);
            expq.push_back(w);
            bus.mem_rdata = w;
            n_pops++;
        end else bus.mem_rdata = 8'($urandom);
        pend_m = pop;
    endtask
    task automatic do_reset();
        rrst_n = 1'b0;
        bus.rempty = 1'b1;
        bus.rready = 1'b0;
        bus.mem_rdata = 8'($urandom);
        expq.delete();
        src.delete();
        pend_m = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rrst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        do_reset();
        drive(1'b1, 1'b0);
        n_cmp++; if (bus.rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid got %b want 0", bus.rvalid); end
        n_cmp++; if (bus.rdata !== 8'h00) begin n_bad++; $display("FAIL reset_rdata got %h want 00", bus.rdata); end
        n_cmp++; if (bus.occupancy !== 2'd0) begin n_bad++; $display("FAIL reset_occ got %0d want 0", bus.occupancy); end
        n_cmp++; if (bus.rinc !== 1'b0) begin n_bad++; $display("FAIL reset_rinc got %b want 0", bus.rinc); end
    endtask
    task automatic test_stream();
        logic [7:0] want[3];
        want = '{8'h11, 8'h22, 8'h33};
        do_reset();
        src = '{8'h11, 8'h22, 8'h33};
        for (int c = 0; c < 6; c++) begin
            drive(c >= 3, 1'b1);
            if (c == 0) begin n_cmp++; if (bus.rinc !== 1'b1) begin n_bad++; $display("FAIL stream_rinc0 got %b want 1", bus.rinc); end end
            if (c == 1) begin n_cmp++; if (bus.rvalid !== 1'b0) begin n_bad++; $display("FAIL stream_latency got rvalid %b want 0", bus.rvalid); end end
            if (c >= 2 && c <= 4) begin
                n_cmp++;
                if ({bus.rvalid, bus.rdata} !== {1'b1, want[c-2]}) begin n_bad++; $display("FAIL stream_word%0d got %b/%h want 1/%h", c - 2, bus.rvalid, bus.rdata, want[c-2]); end
            end
            if (c == 5) begin n_cmp++; if (bus.rvalid !== 1'b0) begin n_bad++; $display("FAIL stream_end got rvalid %b want 0", bus.rvalid); end end
            step();
        end
    endtask
    task automatic test_backpressure();
        do_reset();
        src = '{8'h41, 8'h42};
        n_pops = 0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 1'b0);
            if (c >= 2) begin
                n_cmp++;
                if ({bus.rvalid, bus.rdata} !== {1'b1, 8'h41}) begin n_bad++; $display("FAIL bp_hold c%0d got %b/%h want 1/41", c, bus.rvalid, bus.rdata); end
            end
            step();
        end
        drive(1'b0, 1'b0);
        n_cmp++; if (n_pops !== 2) begin n_bad++; $display("FAIL bp_pops got %0d want 2", n_pops); end
        n_cmp++; if (bus.occupancy !== 2'd2) begin n_bad++; $display("FAIL bp_occ got %0d want 2", bus.occupancy); end
        n_cmp++; if (bus.rinc !== 1'b0) begin n_bad++; $display("FAIL bp_rinc got %b want 0", bus.rinc); end
    endtask
    task automatic test_drain();
        logic [7:0] want[6];
        want = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
        src = '{8'h43, 8'h44, 8'h45, 8'h46};
        for (int c = 0; c < 7; c++) begin
            drive(c >= 4, 1'b1);
            if (c == 0) begin n_cmp++; if (bus.rinc !== 1'b1) begin n_bad++; $display("FAIL drain_rinc got %b want 1", bus.rinc); end end
            if (c < 6) begin
                n_cmp++;
                if ({bus.rvalid, bus.rdata} !== {1'b1, want[c]}) begin n_bad++; $display("FAIL drain_word%0d got %b/%h want 1/%h", c, bus.rvalid, bus.rdata, want[c]); end
            end else begin
                n_cmp++;
                if (bus.rvalid !== 1'b0) begin n_bad++; $display("FAIL drain_end got rvalid %b want 0", bus.rvalid); end
            end
            step();
        end
    endtask
    task automatic test_empty_rise();
        do_reset();
        src = '{8'hA5};
        drive(1'b0, 1'b1);
        n_cmp++; if (bus.rinc !== 1'b1) begin n_bad++; $display("FAIL er_rinc0 got %b want 1", bus.rinc); end
        step();
        drive(1'b1, 1'b1);
        n_cmp++; if ({bus.rinc, bus.rvalid} !== 2'b00) begin n_bad++; $display("FAIL er_pending got rinc/rvalid %b want 00", {bus.rinc, bus.rvalid}); end
        step();
        drive(1'b1, 1'b0);
        n_cmp++; if ({bus.rvalid, bus.rdata} !== {1'b1, 8'hA5}) begin n_bad++; $display("FAIL er_word got %b/%h want 1/a5", bus.rvalid, bus.rdata); end
        step();
        drive(1'b1, 1'b1);
        n_cmp++; if ({bus.rinc, bus.rvalid, bus.rdata} !== {2'b01, 8'hA5}) begin n_bad++; $display("FAIL er_hold got %b/%b/%h want 0/1/a5", bus.rinc, bus.rvalid, bus.rdata); end
        step();
        drive(1'b1, 1'b1);
        n_cmp++; if (bus.rvalid !== 1'b0) begin n_bad++; $display("FAIL er_after got rvalid %b want 0", bus.rvalid); end
    endtask
    task automatic test_reset_mid();
        do_reset();
        src = '{8'h51, 8'h52};
        drive(1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0);
        n_cmp++; if ({bus.rvalid, bus.occupancy, bus.rdata} !== {1'b1, 2'd1, 8'h51}) begin n_bad++; $display("FAIL rm_pre got %b/%0d/%h want 1/1/51", bus.rvalid, bus.occupancy, bus.rdata); end
        #2;
        rrst_n = 1'b0;
        bus.rempty = 1'b1;
        #1;
        n_cmp++; if ({bus.rvalid, bus.occupancy, bus.rdata, bus.rinc} !== {1'b0, 2'd0, 8'h00, 1'b0}) begin n_bad++; $display("FAIL rm_async got %b/%0d/%h/%b want 0/0/00/0", bus.rvalid, bus.occupancy, bus.rdata, bus.rinc); end
        expq.delete();
        src.delete();
        pend_m = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rrst_n = 1'b1;
        @(posedge clk);
        #1;
        src = '{8'h61, 8'h62};
        for (int c = 0; c < 4; c++) begin
            drive(c >= 2, 1'b1);
            if (c == 2) begin n_cmp++; if ({bus.rvalid, bus.rdata} !== {1'b1, 8'h61}) begin n_bad++; $display("FAIL rm_first got %b/%h want 1/61", bus.rvalid, bus.rdata); end end
            if (c == 3) begin n_cmp++; if ({bus.rvalid, bus.rdata} !== {1'b1, 8'h62}) begin n_bad++; $display("FAIL rm_second got %b/%h want 1/62", bus.rvalid, bus.rdata); end end
            step();
        end
    endtask
    task automatic test_random();
        int words, cyc, exp_occ;
        logic e, r, fire_m, rinc_m;
        words = 0;
        cyc = 0;
        do_reset();
        while (words < 1000 && cyc < 20000) begin
            e = ($urandom % 3) == 0;
            r = 1'($urandom % 2);
            drive(e, r);
            exp_occ = expq.size() - (pend_m ? 1 : 0);
            fire_m = (exp_occ != 0) && r;
            rinc_m = !e && ((expq.size() - (fire_m ? 1 : 0)) < 2);
            n_cmp++; if (bus.occupancy !== 2'(exp_occ)) begin n_bad++; $display("FAIL rnd_occ cyc%0d got %0d want %0d", cyc, bus.occupancy, exp_occ); end
            n_cmp++; if (bus.rvalid !== (exp_occ != 0)) begin n_bad++; $display("FAIL rnd_rvalid cyc%0d got %b want %b", cyc, bus.rvalid, exp_occ != 0); end
            n_cmp++; if (bus.rinc !== rinc_m) begin n_bad++; $display("FAIL rnd_rinc cyc%0d got %b want %b", cyc, bus.rinc, rinc_m); end
            if (exp_occ != 0) begin
                n_cmp++; if (bus.rdata !== expq[0]) begin n_bad++; $display("FAIL rnd_order word%0d got %h want %h", words, bus.rdata, expq[0]); end
            end
            if (fire_m) words++;
            step();
            cyc++;
        end
        n_cmp++;
        if (words < 1000) begin n_bad++; $display("FAIL rnd_budget got %0d words want 1000", words); end
    endtask
    initial begin
        rrst_n = 1'b0;
        bus.rempty = 1'b1;
        bus.rready = 1'b0;
        bus.mem_rdata = 8'h00;
        pend_m = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_drain();
        test_empty_rise();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
